// File: rtl/adc_int_to_float.sv
// Converts signed ADC samples to IEEE-754 single-precision floats for the iir_lpf x-input.
// Exact conversion; the leading one is found by shifting one bit per clock.
module adc_int_to_float #(
    parameter int IN_W = 24
) (
    input  logic            i_CLK,
    input  logic            i_RSTN,
    input  logic [IN_W-1:0] i_ADC_DATA,
    input  logic            i_ADC_DATA_VALID,
    output logic            o_ADC_DATA_READY,
    output logic [31:0]     o_X_DATA,
    output logic            o_X_DATA_VALID,
    input  logic            i_X_DATA_READY,
    output logic            o_OVERRUN,
    input  logic            i_OVR_CLR
);

    localparam int K_W = (IN_W > 2) ? $clog2(IN_W) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_PACK = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            sign_q, sign_d;
    logic [IN_W-1:0] mag_q, mag_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [31:0]     x_q, x_d;
    logic            vld_q, vld_d;
    logic            ovr_q, ovr_d;

    logic [7:0]      exp_w;
    logic [22:0]     mant_w;

    // Exponent falls by one per normalising shift; the implicit leading one is dropped.
    assign exp_w  = 8'(127 + IN_W - 1 - int'(k_q));
    assign mant_w = 23'(mag_q[IN_W-2:0]) << (24 - IN_W);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        k_d     = k_q;
        x_d     = x_q;
        vld_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_ADC_DATA_VALID) begin
                    sign_d  = i_ADC_DATA[IN_W-1];
                    // Negation wraps the most negative value onto 2^(IN_W-1), which is its magnitude.
                    mag_d   = i_ADC_DATA[IN_W-1] ? -i_ADC_DATA : i_ADC_DATA;
                    k_d     = '0;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if ((mag_q == '0) || mag_q[IN_W-1]) begin
                    state_d = ST_PACK;
                end else begin
                    mag_d = mag_q << 1;
                    k_d   = k_q + K_W'(1);
                end
            end
            ST_PACK: begin
                x_d     = (mag_q == '0) ? 32'h0000_0000 : {sign_q, exp_w, mant_w};
                state_d = ST_SEND;
            end
            default: begin
                if (i_X_DATA_READY) begin
                    vld_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Set beats clear when both land in the same cycle.
    assign ovr_d = (i_ADC_DATA_VALID && (state_q != ST_IDLE)) ? 1'b1 :
                   (i_OVR_CLR ? 1'b0 : ovr_q);

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            k_q     <= '0;
            x_q     <= 32'h0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            k_q     <= k_d;
            x_q     <= x_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_ADC_DATA_READY = (state_q == ST_IDLE);
    assign o_X_DATA         = x_q;
    assign o_X_DATA_VALID   = vld_q;
    assign o_OVERRUN        = ovr_q;

endmodule

// File: tb/tb_adc_int_to_float.sv
// Self-checking bench for adc_int_to_float: directed vector table, corner sequences
// and randomized samples checked against an arithmetic float model.
module tb_adc_int_to_float;

    localparam int IN_W = 24;

    logic            clk;
    logic            rstn;
    logic [IN_W-1:0] adc_data;
    logic            adc_valid;
    logic            adc_ready;
    logic [31:0]     x_data;
    logic            x_valid;
    logic            x_ready;
    logic            overrun;
    logic            ovr_clr;

    int checks = 0;
    int errors = 0;

    adc_int_to_float #(.IN_W(IN_W)) dut (
        .i_CLK            (clk),
        .i_RSTN           (rstn),
        .i_ADC_DATA       (adc_data),
        .i_ADC_DATA_VALID (adc_valid),
        .o_ADC_DATA_READY (adc_ready),
        .o_X_DATA         (x_data),
        .o_X_DATA_VALID   (x_valid),
        .i_X_DATA_READY   (x_ready),
        .o_OVERRUN        (overrun),
        .i_OVR_CLR        (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0] din;
        logic [31:0]     exp_f;
        int              exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: float from the integer value via its highest set bit.
    function automatic logic [31:0] ref_float(input logic [IN_W-1:0] s, output int lat);
        longint v;
        logic   neg;
        int     p;
        longint m;
        v   = longint'($signed(s));
        neg = (v < 0);
        if (neg) v = -v;
        if (v == 0) begin
            lat = 3;
            return 32'h0;
        end
        p = 0;
        for (int i = 0; i < 40; i++) if ((v >> i) != 0) p = i;
        lat = 3 + (IN_W - 1 - p);
        m   = (v - (longint'(1) << p)) << (23 - p);
        return {neg, 8'(127 + p), m[22:0]};
    endfunction

    // Waits for ready, pulses one sample, returns the result and edges-to-valid (-1 on timeout).
    task automatic convert(input logic [IN_W-1:0] din, output logic [31:0] res, output int lat);
        int w;
        res = '0;
        lat = -1;
        w   = 0;
        while (!adc_ready && w < 100) begin
            tick();
            w++;
        end
        adc_data  = din;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (x_valid) begin
                lat = n;
                res = x_data;
                break;
            end
        end
        if (lat > 0) begin
            tick();
            chk("single_pulse", {31'b0, x_valid}, 32'd0);
            chk("hold_after_valid", x_data, res);
        end
    endtask

    vec_t        vecs[6];
    logic [31:0] res;
    int          lat;
    int          rlat;
    logic [31:0] rexp;
    int          vcnt;
    longint      rv;

    initial begin
        vecs[0] = '{24'h000001, 32'h3F800000, 26};
        vecs[1] = '{24'h800000, 32'hCB000000, 3};
        vecs[2] = '{24'h7FFFFF, 32'h4AFFFFFE, 4};
        vecs[3] = '{24'h000064, 32'h42C80000, 20};
        vecs[4] = '{24'hFFFFFF, 32'hBF800000, 26};
        vecs[5] = '{24'h000000, 32'h00000000, 3};

        rstn = 1'b0; adc_data = '0; adc_valid = 1'b0; x_ready = 1'b1; ovr_clr = 1'b0;
        tick(); tick();
        chk("rst_x_data", x_data, 32'h0);
        chk("rst_x_valid", {31'b0, x_valid}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_ready", {31'b0, adc_ready}, 32'd1);
        rstn = 1'b1;
        tick();

        // Directed table; entry 5 (zero) follows a negative sample to catch sign leakage.
        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].din, res, lat);
            chk($sformatf("vec%0d_data", i), res, vecs[i].exp_f);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        end
        chk("no_overrun_yet", {31'b0, overrun}, 32'd0);

        // Backpressure with a dropped sample during the stall.
        x_ready = 1'b0;
        adc_data = 24'h000001; adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        vcnt = 0;
        for (int n = 0; n < 35; n++) begin
            if (n == 30) begin adc_data = 24'h000005; adc_valid = 1'b1; end
            tick();
            adc_valid = 1'b0;
            if (x_valid) vcnt++;
        end
        chk("stall_no_valid", 32'(vcnt), 32'd0);
        chk("stall_hold_data", x_data, 32'h3F800000);
        chk("stall_ready_low", {31'b0, adc_ready}, 32'd0);
        chk("stall_overrun", {31'b0, overrun}, 32'd1);
        x_ready = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (x_valid) begin
                vcnt++;
                chk("release_data", x_data, 32'h3F800000);
            end
        end
        chk("release_one_pulse", 32'(vcnt), 32'd1);
        chk("dropped_not_sent", x_data, 32'h3F800000);
        chk("idle_after_release", {31'b0, adc_ready}, 32'd1);

        // Clear overrun, then set and clear in the same cycle.
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("ovr_cleared", {31'b0, overrun}, 32'd0);
        adc_data = 24'h000010; adc_valid = 1'b1;
        tick();
        adc_data = 24'h000003; ovr_clr = 1'b1;
        tick();
        adc_valid = 1'b0;
        chk("ovr_set_wins", {31'b0, overrun}, 32'd1);
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr_alone", {31'b0, overrun}, 32'd0);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (x_valid) begin lat = n; res = x_data; break; end
            tick();
        end
        chk("ovr_seq_valid_seen", {31'b0, (lat >= 0)}, 32'd1);
        chk("ovr_seq_data", res, 32'h41800000);

        // Reset mid-normalisation aborts the sample.
        tick();
        adc_data = 24'h000001; adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        rstn = 1'b0;
        tick();
        chk("mid_rst_x_data", x_data, 32'h0);
        chk("mid_rst_valid", {31'b0, x_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, adc_ready}, 32'd1);
        rstn = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, adc_ready}, 32'd1);
        chk("post_rst_overrun", {31'b0, overrun}, 32'd0);
        vcnt = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (x_valid) vcnt++;
        end
        chk("aborted_no_valid", 32'(vcnt), 32'd0);
        convert(24'h000002, res, lat);
        chk("post_rst_data", res, 32'h40000000);
        chk("post_rst_lat", 32'(lat), 32'd25);

        // Randomized samples with a spread of leading-zero counts and signs.
        for (int i = 0; i < 150; i++) begin
            rv = longint'($urandom) >> $urandom_range(8, 31);
            if ($urandom_range(0, 1) == 1) rv = -rv;
            rexp = ref_float(rv[IN_W-1:0], rlat);
            convert(rv[IN_W-1:0], res, lat);
            chk($sformatf("rand%0d_data_%h", i, rv[IN_W-1:0]), res, rexp);
            chk($sformatf("rand%0d_lat", i), 32'(lat), 32'(rlat));
        end
        chk("rand_no_overrun", {31'b0, overrun}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
